// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the alu1 -> alu2 op-code sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_t;

  localparam int unsigned OP_W_DFLT     = 3;
  localparam logic [2:0]  IDLE_OP1_DFLT = 3'b111;
  localparam logic [2:0]  IDLE_OP2_DFLT = 3'b000;

  typedef struct packed {
    logic [OP_W_DFLT-1:0] op1;
    logic [OP_W_DFLT-1:0] op2;
  } prog_entry_t;

endpackage

// File: rtl/alu_seq_progmem.sv
// Per-sample program store: DEPTH op-code pairs, one write port, one combinational read port.
module alu_seq_progmem #(
  parameter int unsigned    OP_W    = 3,
  parameter int unsigned    DEPTH   = 8,
  parameter int unsigned    AW      = $clog2(DEPTH),
  parameter logic [OP_W-1:0] RST_OP1 = '1,
  parameter logic [OP_W-1:0] RST_OP2 = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [OP_W-1:0] wop1,
  input  logic [OP_W-1:0] wop2,
  input  logic [AW-1:0]   raddr,
  output logic [OP_W-1:0] rop1,
  output logic [OP_W-1:0] rop2
);

  logic [2*OP_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {RST_OP1, RST_OP2};
      end
    end else if (we) begin
      mem_q[waddr] <= {wop1, wop2};
    end
  end

  assign {rop1, rop2} = mem_q[raddr];

endmodule

// File: rtl/alu_pair_sequencer.sv
// Steps a small op-code program once per accepted sample, aligning alu1/alu2 ops and the
// valid/frame_done pipe with the two registered ALU stages.
module alu_pair_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned     OP_W     = OP_W_DFLT,
  parameter int unsigned     DEPTH    = 8,
  parameter int unsigned     LEN_W    = 8,
  parameter logic [OP_W-1:0] IDLE_OP1 = OP_W'(IDLE_OP1_DFLT),
  parameter logic [OP_W-1:0] IDLE_OP2 = OP_W'(IDLE_OP2_DFLT),
  localparam int unsigned    AW       = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [AW-1:0]    prog_last,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [OP_W-1:0]  cfg_op1,
  input  logic [OP_W-1:0]  cfg_op2,
  input  logic             validi,
  output logic             readyo,
  output logic [OP_W-1:0]  alu1_op,
  output logic [OP_W-1:0]  alu2_op,
  output logic             valido,
  output logic             busy,
  output logic             frame_done
);

  state_t state_q, state_d;

  logic [AW-1:0]    pc_q, last_q;
  logic [LEN_W-1:0] cnt_q;
  logic [OP_W-1:0]  op2_q;
  logic             v1_q, v2_q, last1_q, last2_q;
  logic [OP_W-1:0]  rd_op1, rd_op2;
  logic             accept, start_ok, cnt_one, prog_we;

  assign accept   = validi & readyo;
  assign start_ok = (state_q == StIdle) & start & (frame_len != '0);
  assign cnt_one  = (cnt_q == LEN_W'(1));
  // Program is frozen while a frame is in flight.
  assign prog_we  = cfg_we & (state_q == StIdle);

  alu_seq_progmem #(
    .OP_W    (OP_W),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .RST_OP1 (IDLE_OP1),
    .RST_OP2 (IDLE_OP2)
  ) u_progmem (
    .clk   (Clk),
    .rst   (rst),
    .we    (prog_we),
    .waddr (cfg_addr),
    .wop1  (cfg_op1),
    .wop2  (cfg_op2),
    .raddr (pc_q),
    .rop1  (rd_op1),
    .rop2  (rd_op2)
  );

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StRun;
      StRun:   if (accept && cnt_one) state_d = StDrain;
      StDrain: if (frame_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    readyo     = 1'b0;
    busy       = 1'b0;
    alu1_op    = IDLE_OP1;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: ;
      StRun: begin
        readyo  = 1'b1;
        busy    = 1'b1;
        alu1_op = rd_op1;
      end
      StDrain: begin
        busy       = 1'b1;
        frame_done = v2_q & last2_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      op2_q   <= IDLE_OP2;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      if (start_ok) begin
        pc_q   <= '0;
        cnt_q  <= frame_len;
        last_q <= prog_last;
      end else if (accept) begin
        pc_q  <= (pc_q == last_q) ? '0 : pc_q + AW'(1);
        cnt_q <= cnt_q - LEN_W'(1);
        op2_q <= rd_op2;
      end
      v1_q    <= accept;
      last1_q <= accept & cnt_one;
      v2_q    <= v1_q;
      last2_q <= last1_q;
    end
  end

  assign alu2_op = op2_q;
  assign valido  = v2_q;

endmodule

// File: tb/tb_alu_pair_sequencer.sv
// Directed bench for alu_pair_sequencer: per-cycle expected outputs are hand-computed.
module tb_alu_pair_sequencer;

  logic       Clk, rst, start, cfg_we, validi;
  logic [7:0] frame_len;
  logic [2:0] prog_last, cfg_addr, cfg_op1, cfg_op2;
  logic       readyo, valido, busy, frame_done;
  logic [2:0] alu1_op, alu2_op;

  int n_checks = 0;
  int n_fail   = 0;

  alu_pair_sequencer dut (
    .Clk        (Clk),
    .rst        (rst),
    .start      (start),
    .frame_len  (frame_len),
    .prog_last  (prog_last),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_op1    (cfg_op1),
    .cfg_op2    (cfg_op2),
    .validi     (validi),
    .readyo     (readyo),
    .alu1_op    (alu1_op),
    .alu2_op    (alu2_op),
    .valido     (valido),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic rdy, input logic [2:0] a1,
                     input logic [2:0] a2, input logic vo, input logic fd, input logic bz);
    check({tag, ".readyo"},     {7'd0, readyo},     {7'd0, rdy});
    check({tag, ".alu1_op"},    {5'd0, alu1_op},    {5'd0, a1});
    check({tag, ".alu2_op"},    {5'd0, alu2_op},    {5'd0, a2});
    check({tag, ".valido"},     {7'd0, valido},     {7'd0, vo});
    check({tag, ".frame_done"}, {7'd0, frame_done}, {7'd0, fd});
    check({tag, ".busy"},       {7'd0, busy},       {7'd0, bz});
  endtask

  task automatic prog(input logic [2:0] a, input logic [2:0] o1, input logic [2:0] o2);
    cfg_we = 1'b1; cfg_addr = a; cfg_op1 = o1; cfg_op2 = o2;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic begin_frame(input logic [7:0] len, input logic [2:0] last);
    start = 1'b1; frame_len = len; prog_last = last;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; cfg_we = 0; validi = 0;
    frame_len = 0; prog_last = 0; cfg_addr = 0; cfg_op1 = 0; cfg_op2 = 0;

    // 1: async reset, then read back the whole program through an 8-sample frame
    #1 rst = 1'b0;
    #1 cyc("rst", 0, 7, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    begin_frame(8'd8, 3'd7);
    validi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("rb%0d", i), 1, 7, 0, (i >= 2), 0, 1);
      tick();
    end
    validi = 1'b0;
    cyc("rb_d0", 0, 7, 0, 1, 0, 1); tick();
    cyc("rb_d1", 0, 7, 0, 1, 1, 1); tick();
    cyc("rb_idle", 0, 7, 0, 0, 0, 0);

    // 2: two-entry program, continuous valid
    prog(3'd0, 3'b001, 3'b010);
    prog(3'd1, 3'b011, 3'b100);
    begin_frame(8'd4, 3'd1);
    validi = 1'b1;
    cyc("t2c0", 1, 1, 0, 0, 0, 1); tick();
    cyc("t2c1", 1, 3, 2, 0, 0, 1); tick();
    cyc("t2c2", 1, 1, 4, 1, 0, 1); tick();
    cyc("t2c3", 1, 3, 2, 1, 0, 1); tick();
    validi = 1'b0;
    cyc("t2c4", 0, 7, 4, 1, 0, 1); tick();
    cyc("t2c5", 0, 7, 4, 1, 1, 1); tick();
    cyc("t2c6", 0, 7, 4, 0, 0, 0);

    // 3: valid pattern 1,0,0,1,1,1 with bubbles holding pc and op2
    begin_frame(8'd4, 3'd1);
    validi = 1; cyc("t3k0", 1, 1, 4, 0, 0, 1); tick();
    validi = 0; cyc("t3k1", 1, 3, 2, 0, 0, 1); tick();
    validi = 0; cyc("t3k2", 1, 3, 2, 1, 0, 1); tick();
    validi = 1; cyc("t3k3", 1, 3, 2, 0, 0, 1); tick();
    validi = 1; cyc("t3k4", 1, 1, 4, 0, 0, 1); tick();
    validi = 1; cyc("t3k5", 1, 3, 2, 1, 0, 1); tick();
    validi = 0;
    cyc("t3k6", 0, 7, 4, 1, 0, 1); tick();
    cyc("t3k7", 0, 7, 4, 1, 1, 1); tick();
    cyc("t3k8", 0, 7, 4, 0, 0, 0);

    // 4: cfg_we and start while busy are both ignored
    begin_frame(8'd2, 3'd1);
    validi = 1;
    cfg_we = 1; cfg_addr = 3'd0; cfg_op1 = 3'b101; cfg_op2 = 3'b110;
    start = 1; frame_len = 8'd9;
    cyc("t4j0", 1, 1, 4, 0, 0, 1); tick();
    cfg_we = 0; start = 0;
    cyc("t4j1", 1, 3, 2, 0, 0, 1); tick();
    validi = 0;
    cyc("t4j2", 0, 7, 4, 1, 0, 1); tick();
    cyc("t4j3", 0, 7, 4, 1, 1, 1); tick();
    cyc("t4j4", 0, 7, 4, 0, 0, 0);
    begin_frame(8'd1, 3'd1);
    validi = 1;
    cyc("t4f0", 1, 1, 4, 0, 0, 1); tick();
    validi = 0;
    cyc("t4f1", 0, 7, 2, 0, 0, 1); tick();
    cyc("t4f2", 0, 7, 2, 1, 1, 1); tick();
    cyc("t4f3", 0, 7, 2, 0, 0, 0);

    // 5: zero-length start ignored; write to entry 0 alongside start is used
    begin_frame(8'd0, 3'd0);
    cyc("t5z0", 0, 7, 2, 0, 0, 0); tick();
    cyc("t5z1", 0, 7, 2, 0, 0, 0);
    cfg_we = 1; cfg_addr = 3'd0; cfg_op1 = 3'b101; cfg_op2 = 3'b110;
    begin_frame(8'd1, 3'd0);
    cfg_we = 0;
    validi = 1;
    cyc("t5f0", 1, 5, 2, 0, 0, 1); tick();
    validi = 0;
    cyc("t5f1", 0, 7, 6, 0, 0, 1); tick();
    cyc("t5f2", 0, 7, 6, 1, 1, 1); tick();
    cyc("t5f3", 0, 7, 6, 0, 0, 0);
    // prog_last = 0 repeats entry 0
    begin_frame(8'd3, 3'd0);
    validi = 1;
    cyc("t5g0", 1, 5, 6, 0, 0, 1); tick();
    cyc("t5g1", 1, 5, 6, 0, 0, 1); tick();
    cyc("t5g2", 1, 5, 6, 1, 0, 1); tick();
    validi = 0;
    cyc("t5g3", 0, 7, 6, 1, 0, 1); tick();
    cyc("t5g4", 0, 7, 6, 1, 1, 1); tick();
    cyc("t5g5", 0, 7, 6, 0, 0, 0);

    // 6: reset mid-frame aborts; program returns to reset contents
    begin_frame(8'd4, 3'd1);
    validi = 1;
    cyc("t6h0", 1, 5, 6, 0, 0, 1); tick();
    cyc("t6h1", 1, 3, 6, 0, 0, 1); tick();
    cyc("t6h2", 1, 5, 4, 1, 0, 1);
    #2 rst = 1'b0;
    #1 cyc("t6rst", 0, 7, 0, 0, 0, 0);
    tick();
    cyc("t6hold", 0, 7, 0, 0, 0, 0);
    validi = 0;
    rst = 1'b1;
    tick();
    prog(3'd1, 3'b011, 3'b100);
    begin_frame(8'd2, 3'd1);
    validi = 1;
    cyc("t6m0", 1, 7, 0, 0, 0, 1); tick();
    cyc("t6m1", 1, 3, 0, 0, 0, 1); tick();
    validi = 0;
    cyc("t6m2", 0, 7, 4, 1, 0, 1); tick();
    cyc("t6m3", 0, 7, 4, 1, 1, 1); tick();
    cyc("t6m4", 0, 7, 4, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
